load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, maximum REQ-state cycles waiting for bus_ack before abort (range 1..255).
REQ-002 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: mem_read  in  2  load size from control unit, 00 none / 01 byte / 10 half / 11 word.
REQ-005 SHALL have port: mem_write  in  2  store size, same encoding as mem_read.
REQ-006 SHALL have ports: load_unsigned  in  1  zero-extend when 1, sign-extend when 0; addr  in  32  ALU result byte address; wdata  in  32  store data, register read2.
REQ-007 SHALL have ports: rdata  out  32  extended load result; stall  out  1  freeze PC/regfile; bus_err  out  1  timeout pulse; misalign  out  1  misaligned-access pulse.
REQ-008 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32  word-aligned; bus_be  out  4; bus_wdata  out  32; bus_ack  in  1; bus_rdata  in  32.

Function
REQ-009 SHALL implement FSM IDLE, REQ, DONE; op_valid = (mem_read != 00) | (mem_write != 00).
REQ-010 SHALL: mem_write nonzero takes priority; mem_read ignored that cycle.
REQ-011 SHALL in IDLE with op_valid and legal alignment latch addr, size, direction, load_unsigned, wdata and go REQ next edge.
REQ-012 SHALL drive bus_* from registers only; bus_req=1 for every cycle in REQ, 0 otherwise; bus_addr = {addr[31:2],2'b00}.
REQ-013 SHALL set bus_be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) / 1100 (addr[1]=1); word 1111; little-endian lanes.
REQ-014 SHALL set bus_wdata: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-015 SHALL in REQ sample bus_ack each edge; on ack go DONE, register extracted/extended lane of bus_rdata into rdata (writes leave rdata unchanged).
REQ-016 SHALL count REQ cycles; if count reaches TIMEOUT_CYCLES without ack go DONE, rdata=0, bus_err=1 during DONE only.
REQ-017 SHALL stall = (IDLE & op_valid & !misalign_trap) | REQ, combinational; stall=0 in DONE so the CPU advances on the edge ending DONE.
REQ-018 SHALL transition DONE -> IDLE unconditionally; an op present in DONE is not accepted until IDLE (back-to-back op latency: 1 IDLE cycle).
REQ-019 SHALL give minimum load latency 3 cycles (IDLE accept, REQ with same-cycle ack, DONE result).
REQ-020 SHALL ignore bus_ack outside REQ.

Reset
REQ-021 SHALL on rst_n=0 immediately force IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, bus_err=0, misalign=0, timeout counter=0.
REQ-022 SHALL abandon an in-flight REQ on reset without completing it; first access after release starts from IDLE.

Configuration
REQ-023 SHALL with MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 issues no bus cycle, misalign=1 combinationally in that IDLE cycle, stall=0, rdata unchanged.
REQ-024 SHALL without MISALIGN_TRAP_EN: misalign tied 0, offending low address bits treated as 0 (half->addr[1],0; word->00) and access proceeds normally.

Verification
REQ-025 SHALL test word store: mem_write=11, addr=0x10, wdata=0xDEADBEEF, ack in 1st REQ cycle -> bus_addr=0x10, bus_be=1111, bus_we=1, stall high 2 cycles.
REQ-026 SHALL test signed byte load: mem_read=01, addr=0x13, load_unsigned=0, bus_rdata=0x80112233 -> bus_be=1000, rdata=0xFFFFFF80; with load_unsigned=1 -> 0x00000080.
REQ-027 SHALL test half load: addr=0x22, bus_rdata=0x7FFF0001, unsigned=0 -> bus_be=1100, rdata=0x00007FFF.
REQ-028 SHALL test timeout: TIMEOUT_CYCLES=4, bus_ack held 0 -> bus_req high exactly 4 cycles, then bus_err=1 and rdata=0 for one cycle, IDLE next.
REQ-029 SHALL test misalignment: word load addr=0x05 -> with macro misalign=1, bus_req never asserts; without macro bus_addr=0x04, bus_be=1111.
REQ-030 SHALL test reset mid-REQ: rst_n low during REQ -> bus_req=0 same cycle, no DONE, next op completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit and the data memory.
// The LSU is the master: it raises bus_req with a word-aligned address,
// byte enables and write data, and the memory answers with bus_ack and,
// for reads, bus_rdata.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns the control unit's byte/half/word load and store
// requests into single word-aligned bus transactions, stalls the pipeline
// while the transaction is outstanding, and returns the extended load data.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned half and
// word accesses are rejected with a misalign pulse instead of being issued
// with their low address bits forced to zero.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mem_read,
    input  logic [1:0]               mem_write,
    input  logic                     load_unsigned,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     stall,
    output logic                     bus_err,
    output logic                     misalign,
    load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  timeout_cnt;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_unsigned;

    logic        is_write;
    logic [1:0]  op_size;
    logic        op_valid;
    logic        misalign_trap;
    logic [1:0]  eff_off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] load_value;

    // Decode the request: stores win over loads, and the byte offset inside
    // the word is forced to the natural alignment of the access size.
    always_comb begin
        is_write = (mem_write != 2'b00);
        op_size  = is_write ? mem_write : mem_read;
        op_valid = (op_size != 2'b00);
        case (op_size)
            2'b01:   eff_off = addr[1:0];
            2'b10:   eff_off = {addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign_trap = ((op_size == 2'b10) && addr[0]) ||
                        ((op_size == 2'b11) && (addr[1:0] != 2'b00));
`else
        misalign_trap = 1'b0;
`endif
    end

    // Byte enables and lane-replicated store data for the access being accepted.
    always_comb begin
        case (op_size)
            2'b01: begin
                be_next    = 4'b0001 << eff_off;
                wdata_next = {4{wdata[7:0]}};
            end
            2'b10: begin
                be_next    = eff_off[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and sign/zero extend it.
    always_comb begin
        lane       = bus.bus_rdata >> {lat_off, 3'b000};
        load_value = lane;
        case (lat_size)
            2'b01:   load_value = {{24{~lat_unsigned & lane[7]}}, lane[7:0]};
            2'b10:   load_value = {{16{~lat_unsigned & lane[15]}}, lane[15:0]};
            default: load_value = lane;
        endcase
    end

    // Pipeline handshake: freeze the CPU while accepting or waiting on the bus;
    // a trapped access is reported instead and lets the CPU move on.
    always_comb begin
        misalign = rst_n && (state == IDLE) && misalign_trap;
        stall    = rst_n && (((state == IDLE) && op_valid && !misalign_trap) ||
                             (state == REQ));
    end

    // Transaction sequencer: accept in IDLE, hold the request until ack or
    // timeout, then spend one DONE cycle presenting the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timeout_cnt   <= 8'd0;
            lat_size      <= 2'b00;
            lat_off       <= 2'b00;
            lat_unsigned  <= 1'b0;
            rdata         <= 32'd0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (op_valid && !misalign_trap) begin
                        state         <= REQ;
                        timeout_cnt   <= 8'd0;
                        lat_size      <= op_size;
                        lat_off       <= eff_off;
                        lat_unsigned  <= load_unsigned;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_write;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= be_next;
                        bus.bus_wdata <= wdata_next;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            rdata <= load_value;
                        end
                    end else if (timeout_cnt == LAST_CNT) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        rdata       <= 32'd0;
                        bus_err     <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    bus_err <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. The bench plays both the CPU and the memory
// and predicts every transaction from the access rules (size, lane, extension,
// timeout) with plain arithmetic.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;
    logic        misalign;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .stall         (stall),
        .bus_err       (bus_err),
        .misalign      (misalign),
        .bus           (bus)
    );

    typedef struct {
        logic        stall_idle;
        logic        mis_idle;
        int          stall_cycles;
        int          req_cycles;
        logic [31:0] addr_seen;
        logic [3:0]  be_seen;
        logic        we_seen;
        logic [31:0] wdata_seen;
        logic [31:0] rdata_done;
        logic        err_done;
        logic        stall_done;
        logic        err_after;
        logic        req_after;
    } obs_t;

    int          checks;
    int          errors;
    logic [31:0] prev_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // What the spec says should happen for one access.
    function automatic obs_t model_op(input logic [1:0] rd, input logic [1:0] wr,
                                      input logic uns, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [31:0] rb,
                                      input int ack_delay, input logic [31:0] prev);
        obs_t        e;
        logic        w;
        int          size;
        int          nbytes;
        int          off;
        logic        trap;
        logic        tmo;
        logic [31:0] mask;
        logic [31:0] val;
        w      = (wr != 2'b00);
        size   = w ? int'(wr) : int'(rd);
        nbytes = (size == 1) ? 1 : (size == 2) ? 2 : 4;
        trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = ((size == 2) && a[0]) || ((size == 3) && (a[1:0] != 2'b00));
`endif
        off  = (int'(a[1:0]) / nbytes) * nbytes;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val  = (rb >> (8 * off)) & mask;
        if (!uns && (nbytes < 4) && val[8 * nbytes - 1]) val = val | ~mask;
        tmo  = (ack_delay >= TO);
        e.stall_idle = !trap;
        e.mis_idle   = trap;
        e.req_cycles = trap ? 0 : (tmo ? TO : ack_delay + 1);
        e.stall_cycles = trap ? 0 : 1 + e.req_cycles;
        e.addr_seen  = {a[31:2], 2'b00};
        e.be_seen    = 4'(((1 << nbytes) - 1) << off);
        e.we_seen    = w;
        for (int i = 0; i < 4; i++) e.wdata_seen[8 * i +: 8] = wd[8 * (i % nbytes) +: 8];
        if (trap)      e.rdata_done = prev;
        else if (tmo)  e.rdata_done = 32'd0;
        else if (w)    e.rdata_done = prev;
        else           e.rdata_done = val;
        e.err_done   = !trap && tmo;
        e.stall_done = 1'b0;
        e.err_after  = 1'b0;
        e.req_after  = 1'b0;
        return e;
    endfunction

    // Present one op for a single cycle, answer it as memory after ack_delay
    // REQ cycles, and record what the DUT did.
    task automatic apply_op(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rb,
                            input int ack_delay, output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        mem_read = rd; mem_write = wr; load_unsigned = uns;
        addr = a; wdata = wd; bus.bus_ack = 1'b0; bus.bus_rdata = rb;
        #1;
        o.stall_idle   = stall;
        o.mis_idle     = misalign;
        o.stall_cycles = int'(stall);
        @(negedge clk);
        mem_read = 2'b00; mem_write = 2'b00;
        for (int c = 0; c < 64; c++) begin
            bus.bus_ack = (c == ack_delay);
            #1;
            if (!bus.bus_req) break;
            if (c == 0) begin
                o.addr_seen  = bus.bus_addr;
                o.be_seen    = bus.bus_be;
                o.we_seen    = bus.bus_we;
                o.wdata_seen = bus.bus_wdata;
            end
            o.req_cycles++;
            o.stall_cycles += int'(stall);
            @(negedge clk);
        end
        bus.bus_ack = 1'b0;
        o.rdata_done = rdata;
        o.err_done   = bus_err;
        o.stall_done = stall;
        @(negedge clk);
        #1;
        o.err_after = bus_err;
        o.req_after = bus.bus_req;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 2'b00; mem_write = 2'b00; load_unsigned = 1'b0;
        addr = 32'd0; wdata = 32'd0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req got %0b want 0", bus.bus_req); end
        checks++; if (bus.bus_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_we got %0b want 0", bus.bus_we); end
        checks++; if (bus.bus_be !== 4'd0) begin errors++; $display("[TB] FAIL reset_bus_be got %h want 0", bus.bus_be); end
        checks++; if (bus.bus_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus_addr got %h want 0", bus.bus_addr); end
        checks++; if (bus.bus_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_bus_wdata got %h want 0", bus.bus_wdata); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err got %0b want 0", bus_err); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %0b want 0", misalign); end
        @(negedge clk);
        rst_n = 1'b1;
        prev_rdata = 32'd0;
    endtask

    task automatic test_word_store();
        obs_t o;
        apply_op(2'b00, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h1234_5678, 0, o);
        checks++; if (o.addr_seen !== 32'h10) begin errors++; $display("[TB] FAIL store_addr got %h want 00000010", o.addr_seen); end
        checks++; if (o.be_seen !== 4'b1111) begin errors++; $display("[TB] FAIL store_be got %b want 1111", o.be_seen); end
        checks++; if (o.we_seen !== 1'b1) begin errors++; $display("[TB] FAIL store_we got %0b want 1", o.we_seen); end
        checks++; if (o.wdata_seen !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_wdata got %h want deadbeef", o.wdata_seen); end
        checks++; if (o.stall_cycles != 2) begin errors++; $display("[TB] FAIL store_stall_cycles got %0d want 2", o.stall_cycles); end
        checks++; if (o.rdata_done !== prev_rdata) begin errors++; $display("[TB] FAIL store_rdata got %h want %h", o.rdata_done, prev_rdata); end
        checks++; if (o.stall_done !== 1'b0) begin errors++; $display("[TB] FAIL store_stall_done got %0b want 0", o.stall_done); end
    endtask

    task automatic test_byte_load();
        obs_t o;
        apply_op(2'b01, 2'b00, 1'b0, 32'h13, 32'd0, 32'h8011_2233, 0, o);
        checks++; if (o.be_seen !== 4'b1000) begin errors++; $display("[TB] FAIL byte_be got %b want 1000", o.be_seen); end
        checks++; if (o.rdata_done !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL byte_signed got %h want ffffff80", o.rdata_done); end
        checks++; if (o.stall_cycles != 2) begin errors++; $display("[TB] FAIL byte_stall_cycles got %0d want 2", o.stall_cycles); end
        apply_op(2'b01, 2'b00, 1'b1, 32'h13, 32'd0, 32'h8011_2233, 0, o);
        checks++; if (o.rdata_done !== 32'h0000_0080) begin errors++; $display("[TB] FAIL byte_unsigned got %h want 00000080", o.rdata_done); end
        prev_rdata = 32'h0000_0080;
    endtask

    task automatic test_half_load();
        obs_t o;
        apply_op(2'b10, 2'b00, 1'b0, 32'h22, 32'd0, 32'h7FFF_0001, 0, o);
        checks++; if (o.be_seen !== 4'b1100) begin errors++; $display("[TB] FAIL half_be got %b want 1100", o.be_seen); end
        checks++; if (o.addr_seen !== 32'h20) begin errors++; $display("[TB] FAIL half_addr got %h want 00000020", o.addr_seen); end
        checks++; if (o.rdata_done !== 32'h0000_7FFF) begin errors++; $display("[TB] FAIL half_rdata got %h want 00007fff", o.rdata_done); end
        prev_rdata = 32'h0000_7FFF;
    endtask

    task automatic test_timeout();
        obs_t o;
        apply_op(2'b11, 2'b00, 1'b0, 32'h100, 32'd0, 32'hCAFE_F00D, 1000, o);
        checks++; if (o.req_cycles != TO) begin errors++; $display("[TB] FAIL timeout_req_cycles got %0d want %0d", o.req_cycles, TO); end
        checks++; if (o.err_done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got %0b want 1", o.err_done); end
        checks++; if (o.rdata_done !== 32'd0) begin errors++; $display("[TB] FAIL timeout_rdata got %h want 0", o.rdata_done); end
        checks++; if (o.err_after !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_after got %0b want 0", o.err_after); end
        checks++; if (o.req_after !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req_after got %0b want 0", o.req_after); end
        prev_rdata = 32'd0;
    endtask

    task automatic test_misalign();
        obs_t o;
        obs_t e;
        e = model_op(2'b11, 2'b00, 1'b0, 32'h05, 32'd0, 32'h0BAD_F00D, 0, prev_rdata);
        apply_op(2'b11, 2'b00, 1'b0, 32'h05, 32'd0, 32'h0BAD_F00D, 0, o);
`ifdef MISALIGN_TRAP_EN
        checks++; if (o.mis_idle !== 1'b1) begin errors++; $display("[TB] FAIL misalign_flag got %0b want 1", o.mis_idle); end
        checks++; if (o.stall_idle !== 1'b0) begin errors++; $display("[TB] FAIL misalign_stall got %0b want 0", o.stall_idle); end
        checks++; if (o.req_cycles != 0) begin errors++; $display("[TB] FAIL misalign_req_cycles got %0d want 0", o.req_cycles); end
`else
        checks++; if (o.mis_idle !== 1'b0) begin errors++; $display("[TB] FAIL misalign_flag got %0b want 0", o.mis_idle); end
        checks++; if (o.addr_seen !== 32'h04) begin errors++; $display("[TB] FAIL misalign_addr got %h want 00000004", o.addr_seen); end
        checks++; if (o.be_seen !== 4'b1111) begin errors++; $display("[TB] FAIL misalign_be got %b want 1111", o.be_seen); end
`endif
        checks++; if (o.rdata_done !== e.rdata_done) begin errors++; $display("[TB] FAIL misalign_rdata got %h want %h", o.rdata_done, e.rdata_done); end
        prev_rdata = e.rdata_done;
    endtask

    task automatic test_write_priority();
        obs_t o;
        apply_op(2'b01, 2'b11, 1'b0, 32'h44, 32'h0102_0304, 32'hFFFF_FFFF, 1, o);
        checks++; if (o.we_seen !== 1'b1) begin errors++; $display("[TB] FAIL priority_we got %0b want 1", o.we_seen); end
        checks++; if (o.be_seen !== 4'b1111) begin errors++; $display("[TB] FAIL priority_be got %b want 1111", o.be_seen); end
        checks++; if (o.rdata_done !== prev_rdata) begin errors++; $display("[TB] FAIL priority_rdata got %h want %h", o.rdata_done, prev_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rb1;
        logic [31:0] rb2;
        rb1 = $urandom;
        rb2 = $urandom;
        @(negedge clk);
        mem_read = 2'b11; mem_write = 2'b00; load_unsigned = 1'b0;
        addr = 32'h40; bus.bus_ack = 1'b1; bus.bus_rdata = rb1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_stall got %0b want 1", stall); end
        @(negedge clk); #1;
        checks++; if (bus.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req1 got %0b want 1", bus.bus_req); end
        @(negedge clk); #1;
        checks++; if (rdata !== rb1) begin errors++; $display("[TB] FAIL b2b_rdata1 got %h want %h", rdata, rb1); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_stall got %0b want 0", stall); end
        @(negedge clk);
        bus.bus_rdata = rb2;
        #1;
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap got %0b want 0", bus.bus_req); end
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reaccept_stall got %0b want 1", stall); end
        @(negedge clk);
        mem_read = 2'b00;
        #1;
        checks++; if (bus.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req2 got %0b want 1", bus.bus_req); end
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        checks++; if (rdata !== rb2) begin errors++; $display("[TB] FAIL b2b_rdata2 got %h want %h", rdata, rb2); end
        prev_rdata = rb2;
    endtask

    task automatic test_reset_mid_req();
        obs_t o;
        logic [31:0] rb;
        @(negedge clk);
        mem_read = 2'b11; mem_write = 2'b00; addr = 32'h80; bus.bus_ack = 1'b0;
        @(negedge clk);
        mem_read = 2'b00;
        #1;
        checks++; if (bus.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL rstreq_in_req got %0b want 1", bus.bus_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_req_drop got %0b want 0", bus.bus_req); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL rstreq_rdata got %h want 0", rdata); end
        @(negedge clk);
        bus.bus_ack = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        checks++; if (bus.bus_req !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_no_done got req %0b err %0b want 0 0", bus.bus_req, bus_err); end
        prev_rdata = 32'd0;
        rb = $urandom;
        apply_op(2'b11, 2'b00, 1'b0, 32'h84, 32'd0, rb, 2, o);
        checks++; if (o.rdata_done !== rb) begin errors++; $display("[TB] FAIL rstreq_next_op got %h want %h", o.rdata_done, rb); end
        checks++; if (o.req_cycles != 3) begin errors++; $display("[TB] FAIL rstreq_next_req_cycles got %0d want 3", o.req_cycles); end
        prev_rdata = rb;
    endtask

    task automatic test_random();
        obs_t o;
        obs_t e;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rb;
        int          dly;
        int          kind;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            wr   = (kind == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            uns  = 1'($urandom_range(0, 1));
            a    = $urandom;
            wd   = $urandom;
            rb   = $urandom;
            dly  = $urandom_range(0, 5);
            e = model_op(rd, wr, uns, a, wd, rb, dly, prev_rdata);
            apply_op(rd, wr, uns, a, wd, rb, dly, o);
            checks++; if (o.stall_idle !== e.stall_idle) begin errors++; $display("[TB] FAIL rnd%0d_stall_idle got %0b want %0b", n, o.stall_idle, e.stall_idle); end
            checks++; if (o.mis_idle !== e.mis_idle) begin errors++; $display("[TB] FAIL rnd%0d_misalign got %0b want %0b", n, o.mis_idle, e.mis_idle); end
            checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("[TB] FAIL rnd%0d_req_cycles got %0d want %0d", n, o.req_cycles, e.req_cycles); end
            if (e.req_cycles > 0) begin
                checks++; if (o.addr_seen !== e.addr_seen) begin errors++; $display("[TB] FAIL rnd%0d_addr got %h want %h", n, o.addr_seen, e.addr_seen); end
                checks++; if (o.be_seen !== e.be_seen) begin errors++; $display("[TB] FAIL rnd%0d_be got %b want %b", n, o.be_seen, e.be_seen); end
                checks++; if (o.we_seen !== e.we_seen) begin errors++; $display("[TB] FAIL rnd%0d_we got %0b want %0b", n, o.we_seen, e.we_seen); end
                if (e.we_seen) begin
                    checks++; if (o.wdata_seen !== e.wdata_seen) begin errors++; $display("[TB] FAIL rnd%0d_wdata got %h want %h", n, o.wdata_seen, e.wdata_seen); end
                end
            end
            checks++; if (o.rdata_done !== e.rdata_done) begin errors++; $display("[TB] FAIL rnd%0d_rdata got %h want %h", n, o.rdata_done, e.rdata_done); end
            checks++; if (o.err_done !== e.err_done) begin errors++; $display("[TB] FAIL rnd%0d_err got %0b want %0b", n, o.err_done, e.err_done); end
            checks++; if (o.err_after !== e.err_after) begin errors++; $display("[TB] FAIL rnd%0d_err_after got %0b want %0b", n, o.err_after, e.err_after); end
            prev_rdata = e.rdata_done;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_rdata = 32'd0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_load();
        test_timeout();
        test_misalign();
        test_write_priority();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
